// File: rtl/flap_ctrl.sv
// Flap game controller: key synchronizer and edge detect, game-tick divider, IDLE/RUN/DEAD FSM.
// All outputs registered; a press acts on the 3rd edge after key_n falls; no backpressure (strobe outputs).
module flap_ctrl #(
    parameter int TICK_DIV  = 1024,
    parameter int SCORE_MAX = 999
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_n,
    input  logic       collide,
    output logic       enable,
    output logic       up,
    output logic       gameOver,
    output logic [9:0] score
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST_CNT  = CW'(TICK_DIV - 1);
    localparam logic [9:0]    SCORE_TOP = 10'(SCORE_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } state_t;

    state_t state, stateNxt;

    // Synchronizer stores the inverted key, so 0 means released.
    logic keySync1, keySync2, keyPrev;
    logic press;

    logic [CW-1:0] tickCnt, cntNxt;
    logic          flapPend, pendNxt;
    logic          enableNxt, upNxt, gameOverNxt;
    logic [9:0]    scoreNxt;
    logic          atTick;

    assign press  = keySync2 & ~keyPrev;
    assign atTick = (state == RUN) && (tickCnt == LAST_CNT);

    // State register together with all registered datapath and outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            keySync1 <= 1'b0;
            keySync2 <= 1'b0;
            keyPrev  <= 1'b0;
            tickCnt  <= '0;
            flapPend <= 1'b0;
            enable   <= 1'b0;
            up       <= 1'b0;
            gameOver <= 1'b0;
            score    <= '0;
        end else begin
            state    <= stateNxt;
            keySync1 <= ~key_n;
            keySync2 <= keySync1;
            keyPrev  <= keySync2;
            tickCnt  <= cntNxt;
            flapPend <= pendNxt;
            enable   <= enableNxt;
            up       <= upNxt;
            gameOver <= gameOverNxt;
            score    <= scoreNxt;
        end
    end

    always_comb begin
        stateNxt = state;
        case (state)
            IDLE:    if (press)   stateNxt = RUN;
            RUN:     if (collide) stateNxt = DEAD;
            DEAD:    if (press)   stateNxt = IDLE;
            default: stateNxt = IDLE;
        endcase
    end

    // A tick due on the collision edge still issues, so tick logic ignores collide.
    always_comb begin
        cntNxt      = tickCnt;
        pendNxt     = flapPend;
        scoreNxt    = score;
        enableNxt   = 1'b0;
        upNxt       = 1'b0;
        gameOverNxt = (stateNxt == DEAD);
        case (state)
            IDLE: begin
                if (press) begin
                    cntNxt   = '0;
                    scoreNxt = '0;
                    pendNxt  = 1'b0;
                end
            end
            RUN: begin
                cntNxt = (tickCnt == LAST_CNT) ? '0 : tickCnt + 1'b1;
                if (atTick) begin
                    enableNxt = 1'b1;
                    upNxt     = flapPend | press;
                    pendNxt   = 1'b0;
                    scoreNxt  = (score >= SCORE_TOP) ? score : score + 10'd1;
                end else if (press) begin
                    pendNxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
